// File: rtl/exec_muldiv_ctrl_pkg.sv
// Shared constants for the execute-stage multiply/divide sequencer:
// operation encodings, FSM state encodings and the default datapath width.
package exec_md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/exec_muldiv_ctrl_if.sv
// Execute-stage <-> mul/div sequencer signals. Handshake: the pipeline holds start
// with its operands until a cycle where stall is low; done pulses once when HI/LO update.
interface exec_muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, md_op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  stall, busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, md_op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output stall, busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/exec_muldiv_ctrl_md_iter.sv
// One iteration of the shared shift/add (multiply) or restoring shift/subtract
// (divide) datapath. Accumulator layout: {upper half, lower half}.
module md_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opb,
  input  logic [CW-1:0]      i_cnt,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [CW-1:0]      o_cnt
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;
  logic           w_no_borrow;

  assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opb} : '0);
  assign w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, i_opb};
  // The partial remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag.
  assign w_no_borrow = ~w_diff[WIDTH];

  always_comb begin
    o_acc = '0;
    if (i_is_div) begin
      o_acc = {(w_no_borrow ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
               i_acc[WIDTH-2:0], w_no_borrow};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

  assign o_cnt = i_cnt - CW'(1);

endmodule

// File: rtl/exec_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the pipeline
// until the result is committed and also services MTHI/MTLO.
module exec_muldiv_ctrl
  import exec_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  exec_muldiv_ctrl_if.slave md
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         r_state;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_start_go;
  logic               w_div0;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q_raw;
  logic [WIDTH-1:0]   w_r_raw;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_signed   = ~md.md_op[0];
  assign w_a_neg    = w_signed & md.src_a[WIDTH-1];
  assign w_b_neg    = w_signed & md.src_b[WIDTH-1];
  assign w_abs_a    = w_a_neg ? -md.src_a : md.src_a;
  assign w_abs_b    = w_b_neg ? -md.src_b : md.src_b;
  assign w_start_go = (r_state == S_IDLE) & md.start & ~md.flush;
  assign w_div0     = w_start_go & md.md_op[1] & (md.src_b == '0);

  md_iter #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opb    (r_opb),
    .i_cnt    (r_cnt),
    .o_acc    (w_acc_nxt),
    .o_cnt    (w_cnt_nxt)
  );

  // Magnitudes were iterated; restore signs. Remainder follows the dividend.
  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_q_raw  = r_acc[WIDTH-1:0];
  assign w_r_raw  = r_acc[2*WIDTH-1:WIDTH];
  assign w_quot   = r_neg_q ? -w_q_raw : w_q_raw;
  assign w_rem    = r_neg_r ? -w_r_raw : w_r_raw;
  assign w_fix_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (md.hi_we) r_hi <= md.wdata;
          if (md.lo_we) r_lo <= md.wdata;
          if (w_start_go) begin
            r_is_div <= md.md_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
            r_opb    <= w_abs_b;
            r_cnt    <= CW'(WIDTH - 1);
            r_busy   <= 1'b1;
            if (w_div0) begin
              r_hi    <= md.src_a;
              r_lo    <= '1;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (md.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        S_FIX: begin
          if (md.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Released in DONE so the held instruction retires in the same cycle done pulses.
  assign md.stall     = w_start_go | (r_busy & (r_state != S_DONE));
  assign md.busy      = r_busy;
  assign md.done      = r_done;
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;
  assign md.dbg_state = r_state;

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Directed plus randomized checks of the mul/div sequencer against a plain-arithmetic model.
module tb_exec_muldiv_ctrl;
  import exec_md_pkg::*;

  localparam int W = MD_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  exec_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  exec_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} for one instruction.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == MD_DIV) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp;
    int exp_done, got_done, stall_bad, busy_at_done;
    exp       = ref_md(op, a, b);
    exp_done  = (op[1] && b == 32'd0) ? 1 : W + 2;
    got_done  = -1;
    stall_bad = 0;
    busy_at_done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    for (int c = 0; c <= W + 10; c++) begin
      #1;
      if (bus.stall !== (c < exp_done)) stall_bad++;
      if (bus.done === 1'b1) begin
        got_done     = c;
        busy_at_done = int'(bus.busy);
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " done_cycle"}, 64'(got_done), 64'(exp_done));
    check({tag, " stall_profile_errs"}, 64'(stall_bad), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy_at_done), 64'd1);
    check({tag, " hi"}, {32'b0, bus.hi}, {32'b0, exp[63:32]});
    check({tag, " lo"}, {32'b0, bus.lo}, {32'b0, exp[31:0]});
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int sel, done_seen;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.md_op = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset hi", {32'b0, bus.hi}, 64'd0);
    check("reset lo", {32'b0, bus.lo}, 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset state", 64'(bus.dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;

    run_op("mult_neg1x2", MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("multu_ffx2", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0", MD_DIVU, 32'h0000_0007, 32'h0000_0000);
    run_op("div_7_m2", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE);

    // MTHI preload, then a flushed divide must leave HI untouched and never signal done.
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    #1;
    check("mthi hi", {32'b0, bus.hi}, 64'h1234);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = MD_DIVU;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.done === 1'b1) done_seen++;
      @(negedge clk);
    end
    bus.flush = 1'b1;
    #1;
    if (bus.done === 1'b1) done_seen++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flush state_idle", 64'(bus.dbg_state), 64'(S_IDLE));
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush hi_kept", {32'b0, bus.hi}, 64'h1234);
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
    end
    check("flush no_done", 64'(done_seen), 64'd0);
    check("flush hi_still", {32'b0, bus.hi}, 64'h1234);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7);

    for (int n = 0; n < 12; n++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 6);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = $urandom_range(1, 9);
      if (sel == 2) b = 32'hFFFF_FFFF;
      if (sel == 3) a = 32'h8000_0000;
      run_op($sformatf("rand%0d_op%0d", n, op), op, a, b);
    end

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.start = 1'b1;
    bus.md_op = MD_MULT;
    bus.src_a = 32'd3;
    bus.src_b = 32'd5;
    #1;
    check("pre_rst lo", {32'b0, bus.lo}, 64'h5A5A_5A5A);
    for (int c = 0; c < 5; c++) @(negedge clk);
    rst_n     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst stall", 64'(bus.stall), 64'd0);
    check("midrst hi", {32'b0, bus.hi}, 64'd0);
    check("midrst lo", {32'b0, bus.lo}, 64'd0);
    check("midrst done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
    end
    check("midrst no_done", 64'(done_seen), 64'd0);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_CAFE;
    @(negedge clk);
    bus.lo_we = 1'b0;
    #1;
    check("mtlo lo", {32'b0, bus.lo}, 64'hCAFE);
    check("mtlo hi_kept", {32'b0, bus.hi}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
